pc_gen: RTL and testbench



---
 rtl/mips_defs.sv | 10 +
 rtl/pc_incr.sv | 11 +
 rtl/pc_gen.sv | 79 +++++++
 tb/tb_pc_gen.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared MIPS front-end constants: default reset/exception vectors and PC generator state encodings.
package mips_defs;
   localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0180;

   typedef enum logic {
      RUN  = 1'b0,
      PEND = 1'b1
   } pc_state_e;
endpackage

// File: rtl/pc_incr.sv
// Sequential-address adder, pc + INC modulo 2^W.
// Purely combinational with no flow control; shared by the link value and the branch-target path.
module pc_incr #(
   parameter int W   = 32,
   parameter int INC = 4
) (
   input  logic [W-1:0] pc,
   output logic [W-1:0] npc
);
   assign npc = pc + W'(INC);
endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: reset/exception/redirect/hold/increment, 1-cycle load latency; a redirect seen under stall is buffered until the stall clears.
// Optional PCGEN_ALIGN_CHECK_EN traps misaligned redirect targets to EXC_VEC and pulses misalign_o.
module pc_gen
   import mips_defs::*;
#(
   parameter int           W         = 32,
   parameter int           INC       = 4,
   parameter logic [W-1:0] RESET_VEC = W'(DEF_RESET_VEC),
   parameter logic [W-1:0] EXC_VEC   = W'(DEF_EXC_VEC)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         stall_i,
   input  logic         redir_valid_i,
   input  logic [W-1:0] redir_target_i,
   input  logic         exc_valid_i,
   output logic [W-1:0] pc_o,
   output logic [W-1:0] npc_o,
   output logic         flush_o,
`ifdef PCGEN_ALIGN_CHECK_EN
   output logic         misalign_o,
`endif
   output logic         pend_o
);
   pc_state_e    state;
   logic [W-1:0] pend_tgt;
   logic [W-1:0] ld_tgt;

   pc_incr #(.W(W), .INC(INC)) u_incr (
      .pc  (pc_o),
      .npc (npc_o)
   );

   // A fresh unstalled redirect wins over whatever is buffered.
   assign ld_tgt = (redir_valid_i && !stall_i) ? redir_target_i : pend_tgt;
   assign pend_o = (state == PEND);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_o       <= RESET_VEC;
         flush_o    <= 1'b0;
         pend_tgt   <= '0;
         state      <= RUN;
`ifdef PCGEN_ALIGN_CHECK_EN
         misalign_o <= 1'b0;
`endif
      end else begin
         flush_o    <= 1'b0;
`ifdef PCGEN_ALIGN_CHECK_EN
         misalign_o <= 1'b0;
`endif
         if (exc_valid_i) begin
            pc_o     <= EXC_VEC;
            flush_o  <= 1'b1;
            pend_tgt <= '0;
            state    <= RUN;
         end else if (redir_valid_i && stall_i) begin
            pend_tgt <= redir_target_i;
            state    <= PEND;
         end else if (!stall_i && (redir_valid_i || state == PEND)) begin
            flush_o <= 1'b1;
            state   <= RUN;
`ifdef PCGEN_ALIGN_CHECK_EN
            // Buffered targets are only checked here, when they are actually applied.
            if (ld_tgt[1:0] != 2'b00) begin
               pc_o       <= EXC_VEC;
               misalign_o <= 1'b1;
            end else begin
               pc_o <= ld_tgt;
            end
`else
            pc_o <= ld_tgt;
`endif
         end else if (!stall_i) begin
            pc_o <= npc_o;
         end
      end
   end
endmodule

// File: tb/tb_pc_gen.sv
// Directed plus randomized check of pc_gen at W=32 and W=8 against a rule-level reference model.
module tb_pc_gen;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        redir;
   logic [31:0] target;
   logic        exc;

   logic [31:0] pc32, npc32;
   logic        flush32, pend32;
   logic [7:0]  pc8, npc8;
   logic        flush8, pend8;
`ifdef PCGEN_ALIGN_CHECK_EN
   logic        mis32, mis8;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   // reference model state per instance: 0 = W32, 1 = W8
   logic [31:0] m_pc[2];
   logic        m_pend[2];
   logic [31:0] m_ptgt[2];
   logic        m_flush[2];
   logic        m_mis[2];

   always #5 clk = ~clk;

   pc_gen #(.W(32)) dut32 (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall_i        (stall),
      .redir_valid_i  (redir),
      .redir_target_i (target),
      .exc_valid_i    (exc),
      .pc_o           (pc32),
      .npc_o          (npc32),
      .flush_o        (flush32),
`ifdef PCGEN_ALIGN_CHECK_EN
      .misalign_o     (mis32),
`endif
      .pend_o         (pend32)
   );

   pc_gen #(.W(8), .INC(4), .RESET_VEC(8'h00), .EXC_VEC(8'h80)) dut8 (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall_i        (stall),
      .redir_valid_i  (redir),
      .redir_target_i (target[7:0]),
      .exc_valid_i    (exc),
      .pc_o           (pc8),
      .npc_o          (npc8),
      .flush_o        (flush8),
`ifdef PCGEN_ALIGN_CHECK_EN
      .misalign_o     (mis8),
`endif
      .pend_o         (pend8)
   );

   function automatic logic [31:0] msk(int k);
      return (k == 1) ? 32'h0000_00FF : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] evec(int k);
      return (k == 1) ? 32'h0000_0080 : 32'h0000_0180;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_pc[k] = 32'h0; m_pend[k] = 1'b0; m_ptgt[k] = 32'h0;
         m_flush[k] = 1'b0; m_mis[k] = 1'b0;
      end
   endtask

   // One clock edge of the priority rules, evaluated on the inputs present at the edge.
   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         logic        take;
         logic [31:0] dest;
         logic [31:0] t;
         take = 1'b0;
         dest = 32'h0;
         t = target & msk(k);
         m_flush[k] = 1'b0;
         m_mis[k] = 1'b0;
         if (exc) begin
            m_pc[k] = evec(k); m_flush[k] = 1'b1; m_pend[k] = 1'b0; m_ptgt[k] = 32'h0;
         end else if (redir && !stall) begin
            take = 1'b1; dest = t; m_pend[k] = 1'b0;
         end else if (redir) begin
            m_ptgt[k] = t; m_pend[k] = 1'b1;
         end else if (m_pend[k] && !stall) begin
            take = 1'b1; dest = m_ptgt[k]; m_pend[k] = 1'b0;
         end else if (!stall) begin
            m_pc[k] = (m_pc[k] + 32'd4) & msk(k);
         end
         if (take) begin
            m_flush[k] = 1'b1;
`ifdef PCGEN_ALIGN_CHECK_EN
            if (dest % 4 != 0) begin
               m_pc[k] = evec(k); m_mis[k] = 1'b1;
            end else begin
               m_pc[k] = dest;
            end
`else
            m_pc[k] = dest;
`endif
         end
      end
   endtask

   task automatic check_all();
      chk("pc32",    pc32,            m_pc[0]);
      chk("npc32",   npc32,           m_pc[0] + 32'd4);
      chk("flush32", {31'h0, flush32}, {31'h0, m_flush[0]});
      chk("pend32",  {31'h0, pend32},  {31'h0, m_pend[0]});
      chk("pc8",     {24'h0, pc8},     m_pc[1]);
      chk("npc8",    {24'h0, npc8},    (m_pc[1] + 32'd4) & 32'hFF);
      chk("flush8",  {31'h0, flush8},  {31'h0, m_flush[1]});
      chk("pend8",   {31'h0, pend8},   {31'h0, m_pend[1]});
`ifdef PCGEN_ALIGN_CHECK_EN
      chk("mis32",   {31'h0, mis32},   {31'h0, m_mis[0]});
      chk("mis8",    {31'h0, mis8},    {31'h0, m_mis[1]});
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic drive(input logic s, input logic r, input logic [31:0] t, input logic e);
      stall = s; redir = r; target = t; exc = e;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      model_reset();
      #12;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // sequential fetch from the reset vector
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("seq_pc", pc32, 32'(i * 4));
      end

      // unstalled redirect at pc=0x10
      drive(1'b0, 1'b1, 32'h40, 1'b0);
      step();
      chk("redir_pc", pc32, 32'h40);
      chk("redir_flush", {31'h0, flush32}, 32'h1);
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      step();
      chk("after_redir_pc", pc32, 32'h44);

      // two redirects under a 3-cycle stall; the later one wins
      drive(1'b1, 1'b1, 32'h80, 1'b0); step();
      drive(1'b1, 1'b1, 32'h90, 1'b0); step();
      drive(1'b1, 1'b0, 32'h0, 1'b0);  step();
      chk("stall_hold_pc", pc32, 32'h44);
      chk("stall_pend", {31'h0, pend32}, 32'h1);
      drive(1'b0, 1'b0, 32'h0, 1'b0);  step();
      chk("pend_apply_pc", pc32, 32'h90);
      chk("pend_apply_flush", {31'h0, flush32}, 32'h1);

      // exception overrides stall, redirect and a pending target
      drive(1'b1, 1'b1, 32'hA0, 1'b0); step();
      drive(1'b1, 1'b1, 32'h80, 1'b1); step();
      chk("exc_pc", pc32, 32'h180);
      chk("exc_pend", {31'h0, pend32}, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b0);  step();
      chk("exc_discard_pc", pc32, 32'h184);

      // wrap on the 8-bit instance
      drive(1'b0, 1'b1, 32'hFC, 1'b0); step();
      chk("w8_fc_npc", {24'h0, npc8}, 32'h00);
      drive(1'b0, 1'b0, 32'h0, 1'b0);  step();
      chk("w8_wrap_pc", {24'h0, pc8}, 32'h00);

      // asynchronous reset while a redirect is pending
      drive(1'b1, 1'b1, 32'hC0, 1'b0); step();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      chk("rst_mid_pend_pc", pc32, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // misaligned redirect target
      drive(1'b0, 1'b1, 32'h42, 1'b0); step();
`ifdef PCGEN_ALIGN_CHECK_EN
      chk("misalign_pc", pc32, 32'h180);
      chk("misalign_flag", {31'h0, mis32}, 32'h1);
`else
      chk("unaligned_pc", pc32, 32'h42);
`endif
      drive(1'b0, 1'b0, 32'h0, 1'b0); step();

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [31:0] t;
         t = $urandom;
         if ($urandom_range(3) != 0) t = t & ~32'h3;
         drive($urandom_range(2) == 0, $urandom_range(3) == 0, t, $urandom_range(15) == 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
